sub_serial: RTL and testbench
=============================

// Module: sub_serial
// PURPOSE
//  Bit-serial subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
//  Sits beside the add4_1/full_add1 adder family as the small-area sequential
//  counterpart for slow datapaths.
//  It reuses one full_add1 cell, using a + ~b + ~bin in two's complement.
//  Start/busy/done handshake to the host datapath.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous reset, active-high
//  start   in   1      request; sampled only when busy==0
//  a       in   WIDTH  minuend, captured on accepted start
//  b       in   WIDTH  subtrahend, captured on accepted start
//  bin     in   1      borrow-in, captured on accepted start
//  busy    out  1      high while bits are being processed
//  done    out  1      one-cycle pulse: diff/bout valid
//  diff    out  WIDTH  result a-b-bin mod 2^WIDTH
//  bout    out  1      borrow-out (1 = a < b+bin, unsigned)
// BEHAVIOUR
//  Reset and clock:
//   - One clock (clk). Reset is synchronous, active-high (rst).
//   - All state is updated on clk rising edge only.
//  Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0,
//   shift regs=0, carry flop=0.
//  States:
//   - IDLE: waits for start.
//   - SHIFT: processes bits for WIDTH cycles.
//   - DONE: pulses done for one cycle.
//  IDLE -> SHIFT on start (start=0: stay in IDLE):
//   - load a_sr<=a, b_sr<=b, carry<=~bin, cnt<=0.
//  SHIFT, each cycle:
//   - full_add1(a_sr[0], ~b_sr[0], carry) gives s,c.
//   - res_sr <= {s, res_sr[WIDTH-1:1]}; a_sr,b_sr shift right; carry<=c; cnt++.
//   - Leave for DONE on cnt==WIDTH-1, when the last bit is processed that cycle.
//  DONE, for 1 cycle:
//   - done=1, busy=0.
//   - diff=res_sr, bout=~carry.
//   - Then go to IDLE; if start=1 in DONE, go straight to SHIFT and load new operands.
//  busy=1 exactly in SHIFT.
//  Latency: start sampled at edge N -> done high in cycle N+WIDTH+1.
//   Throughput is one op per WIDTH+1 cycles.
//  diff/bout are registered and hold their value until the next DONE.
//   They do not change during SHIFT; the result goes to diff only when entering DONE.
//  start while busy=1: ignored, no effect on the operation in flight, no queuing.
//  a/b/bin changing after the accepted start: no effect.
//  rst mid-operation: abort, return to reset values next edge, no done pulse.
//  rst and start in the same cycle: rst wins.
//  Wrap-around: diff is modulo 2^WIDTH, e.g. 0-1 gives diff=all-ones, bout=1.
// STRUCTURE
//  Shared include sub_defs.vh: state encoding localparams ST_IDLE=2'd0,
//   ST_SHIFT=2'd1, ST_DONE=2'd2; counter width macro CLOG2(WIDTH).
//  Sub-module: one full_add1 instance as the bit-slice (port order a,b,cin,sum,cout).
//   Everything else (FSM, shift regs, counter) is inline.
//  Illegal state 2'd3 -> IDLE.
// TESTING (WIDTH=4)
//  - a=9,b=3,bin=0,start 1 cycle -> busy 4 cycles; done at +5; diff=6, bout=0.
//  - a=3,b=9,bin=0 -> diff=4'hA, bout=1. a=0,b=0,bin=1 -> diff=4'hF, bout=1.
//  - Exhaustive loop over a,b in 0..15, bin in 0..1:
//     {bout,diff} == ({1'b0,a}-b-bin) & 5'h1F.
//  - start pulsed with a=1,b=1 during cycle 2 of busy (op 9-3) -> ignored;
//     result 6, exactly one done.
//  - rst asserted in cycle 2 of SHIFT -> next cycle busy=0,done=0,diff=0,bout=0;
//     no done afterwards.
//  - start held high continuously with a=5,b=2 -> done every 5 cycles, diff=3 each time;
//     DONE->SHIFT back-to-back.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// ---------------------------------------------------------------------------
// sub_serial_pkg
// Shared definitions for the bit-serial subtractor.
//   state_t     : FSM encoding (IDLE=0, SHIFT=1, DONE=2; code 3 is illegal)
//   cntWidth()  : width of the bit counter needed to count 0..WIDTH-1
// ---------------------------------------------------------------------------
package sub_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // The counter only ever has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
   // clamp to one bit so a degenerate width never produces a zero-width vector.
   function automatic int cntWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/sub_serial_full_add1.sv
// ---------------------------------------------------------------------------
// full_add1
// One-bit full adder used as the single arithmetic slice of the serial
// subtractor.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_add1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Plain combinational full adder.
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// The subtraction is done as a + ~b + ~bin through one full_add1 slice.
//   clk    : rising-edge clock
//   rst    : synchronous reset, active-high
//   start  : request, only honoured when busy is low (IDLE or DONE)
//   a, b   : minuend / subtrahend, captured on an accepted start
//   bin    : borrow-in, captured on an accepted start
//   busy   : high exactly while bits are being processed
//   done   : one-cycle pulse when diff/bout carry a fresh result
//   diff   : registered result modulo 2^WIDTH, held until the next done
//   bout   : registered borrow-out (1 when a < b + bin, unsigned)
// ---------------------------------------------------------------------------
module sub_serial
   import sub_serial_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = cntWidth(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_aSr;
   logic [WIDTH-1:0] r_bSr;
   logic [WIDTH-1:0] r_resSr;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic             w_bInv;
   logic             w_sum;
   logic             w_cout;

   // Subtraction as addition: feed the inverted subtrahend bit; the inverted
   // borrow-in is preloaded into the carry flop when an operation starts.
   assign w_bInv = ~r_bSr[0];

   full_add1 u_slice (
      .a    (r_aSr[0]),
      .b    (w_bInv),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // Whole controller and datapath in one clocked block. The result is
   // published on the same edge that processes the last bit, so diff/bout
   // take the final sum bit and final carry straight from the slice rather
   // than waiting for them to land in the shift register. A start seen in
   // DONE reloads operands immediately, giving one op every WIDTH+1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_aSr   <= '0;
         r_bSr   <= '0;
         r_resSr <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_aSr   <= a;
                  r_bSr   <= b;
                  r_carry <= ~bin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               r_resSr <= {w_sum, r_resSr[WIDTH-1:1]};
               r_aSr   <= r_aSr >> 1;
               r_bSr   <= r_bSr >> 1;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_diff  <= {w_sum, r_resSr[WIDTH-1:1]};
                  r_bout  <= ~w_cout;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_sub_serial
// Directed self-checking bench for sub_serial with WIDTH=4. Inputs are
// driven and outputs sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_sub_serial;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [3:0] diff;
   logic       bout;

   int checks;
   int errors;

   sub_serial #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands with a one-cycle start pulse, then wait (bounded) for
   // done, reporting the cycles until done and how many of them were busy.
   task automatic applyStimulus(input logic [3:0] opA, input logic [3:0] opB, input logic opBin,
                                output int lat, output int busyCycles);
      @(negedge clk);
      a = opA; b = opB; bin = opBin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busyCycles = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) busyCycles++;
      end
   endtask

   // Directed sequence.
   initial begin
      int lat;
      int busyCycles;
      int doneCount;
      int doneIdx[3];
      logic [4:0] expVal;
      logic [3:0] seenDiff;

      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_diff", diff, 0);
      checkOutput("reset_bout", bout, 0);

      start = 1'b1; a = 4'd9; b = 4'd3;
      @(negedge clk);
      checkOutput("rst_beats_start", busy, 0);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_reset", busy, 0);

      applyStimulus(4'd9, 4'd3, 1'b0, lat, busyCycles);
      checkOutput("9m3_latency", lat, 5);
      checkOutput("9m3_busy_cycles", busyCycles, 4);
      checkOutput("9m3_diff", diff, 6);
      checkOutput("9m3_bout", bout, 0);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      checkOutput("diff_held", diff, 6);

      applyStimulus(4'd3, 4'd9, 1'b0, lat, busyCycles);
      checkOutput("3m9_diff", diff, 4'hA);
      checkOutput("3m9_bout", bout, 1);

      applyStimulus(4'd0, 4'd0, 1'b1, lat, busyCycles);
      checkOutput("0m0b1_diff", diff, 4'hF);
      checkOutput("0m0b1_bout", bout, 1);

      for (int i = 0; i < 512; i++) begin
         logic [3:0] ea;
         logic [3:0] eb;
         logic       ebin;
         ea = 4'(i >> 5);
         eb = 4'(i >> 1);
         ebin = i[0];
         applyStimulus(ea, eb, ebin, lat, busyCycles);
         expVal = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
         checkOutput($sformatf("exh_a%0d_b%0d_bin%0d", ea, eb, ebin), {bout, diff}, expVal);
      end

      @(negedge clk);
      a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd1; b = 4'd1; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      doneCount = 0;
      seenDiff = '0;
      repeat (12) begin
         @(negedge clk);
         if (done) begin
            doneCount++;
            seenDiff = diff;
         end
      end
      checkOutput("ignored_start_done_count", doneCount, 1);
      checkOutput("ignored_start_diff", seenDiff, 6);

      a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_diff", diff, 0);
      checkOutput("abort_bout", bout, 0);
      rst = 1'b0;
      doneCount = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abort_no_done", doneCount, 0);

      a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
      doneCount = 0;
      doneIdx = '{0, 0, 0};
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 6) checkOutput("b2b_busy_after_done", busy, 1);
         if (done) begin
            if (doneCount < 3) doneIdx[doneCount] = c;
            doneCount++;
            checkOutput($sformatf("b2b_diff_c%0d", c), diff, 3);
         end
      end
      start = 1'b0;
      checkOutput("b2b_done_count", doneCount, 3);
      checkOutput("b2b_done0", doneIdx[0], 5);
      checkOutput("b2b_done1", doneIdx[1], 10);
      checkOutput("b2b_done2", doneIdx[2], 15);
      repeat (8) @(negedge clk);
      checkOutput("b2b_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
